// File: rtl/pc_unit.sv
// Program-counter unit: fetch PC, fetch handshake, stall-time redirect queueing, trap redirects.
// Define PC_MISALIGN_TRAP_EN to trap on misaligned redirect targets instead of silently aligning them.
module pc_unit #(
   parameter int OPD_WIDTH = 32,
   parameter int PC_WIDTH  = 12,
   parameter int RESET_PC  = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 branch,
   input  logic                 comp_result,
   input  logic                 jump,
   input  logic [OPD_WIDTH-1:0] alu_result,
   input  logic                 stall,
   input  logic                 trap,
   input  logic [PC_WIDTH-1:0]  trap_vector,
   input  logic                 fetch_ack,
   output logic                 fetch_req,
   output logic [PC_WIDTH-1:0]  pc,
   output logic [OPD_WIDTH-1:0] pc_plus4,
   output logic                 misalign
);

   typedef enum logic [1:0] {BOOT, REQ, STALL, TRAP} state_t;

   localparam logic [PC_WIDTH-1:0] RST_PC = PC_WIDTH'(RESET_PC);

   state_t              state, state_nxt;
   logic [PC_WIDTH-1:0] pc_nxt, pend_pc, pend_nxt, target, tvec, apply_pc;
   logic                pending, pending_nxt, misalign_nxt, redirect, apply;
   logic                unused_bits;

   assign redirect = jump | (branch & comp_result);
   assign tvec     = {trap_vector[PC_WIDTH-1:2], 2'b00};
`ifdef PC_MISALIGN_TRAP_EN
   assign target   = alu_result[PC_WIDTH-1:0];
`else
   assign target   = {alu_result[PC_WIDTH-1:2], 2'b00};
`endif
   assign unused_bits = ^{alu_result[OPD_WIDTH-1:PC_WIDTH], alu_result[1:0], trap_vector[1:0]};

   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      pend_nxt     = pend_pc;
      pending_nxt  = pending;
      misalign_nxt = 1'b0;
      fetch_req    = 1'b0;
      apply        = 1'b0;
      apply_pc     = pc;
      case (state)
         BOOT: state_nxt = REQ;
         REQ: begin
            fetch_req = 1'b1;
            if (trap) begin
               pc_nxt      = tvec;
               pending_nxt = 1'b0;
               state_nxt   = TRAP;
            end else if (fetch_ack && stall) begin
               state_nxt = STALL;
            end else if (fetch_ack) begin
               pending_nxt = 1'b0;
               if (pending) begin
                  apply    = 1'b1;
                  apply_pc = pend_pc;
               end else if (redirect) begin
                  apply    = 1'b1;
                  apply_pc = target;
               end else begin
                  pc_nxt = pc + PC_WIDTH'(4);
               end
            end
         end
         STALL: begin
            if (trap) begin
               pc_nxt      = tvec;
               pending_nxt = 1'b0;
               state_nxt   = TRAP;
            end else begin
               // The most recent redirect seen while stalled is the one that survives.
               if (redirect) begin
                  pend_nxt    = target;
                  pending_nxt = 1'b1;
               end
               if (!stall) begin
                  state_nxt   = REQ;
                  pending_nxt = 1'b0;
                  if (redirect) begin
                     apply    = 1'b1;
                     apply_pc = target;
                  end else if (pending) begin
                     apply    = 1'b1;
                     apply_pc = pend_pc;
                  end
               end
            end
         end
         TRAP: state_nxt = REQ;
         default: state_nxt = BOOT;
      endcase
      if (apply) begin
         pc_nxt = apply_pc;
`ifdef PC_MISALIGN_TRAP_EN
         if (apply_pc[1:0] != 2'b00) begin
            misalign_nxt = 1'b1;
            pc_nxt       = tvec;
            state_nxt    = TRAP;
         end
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= BOOT;
         pc       <= RST_PC;
         pc_plus4 <= OPD_WIDTH'(RST_PC) + OPD_WIDTH'(4);
         pend_pc  <= '0;
         pending  <= 1'b0;
         misalign <= 1'b0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         pc_plus4 <= OPD_WIDTH'(pc_nxt) + OPD_WIDTH'(4);
         pend_pc  <= pend_nxt;
         pending  <= pending_nxt;
         misalign <= misalign_nxt;
      end
   end

endmodule
